uart_tx_fifo: RTL

//   Byte FIFO + drain FSM sitting directly upstream of the UART transmitter in uart_top.

---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter one frame at a time.
// Producers push at full clock rate; the drain FSM pops a byte only when the
// transmitter is idle and hands it over with a one-cycle tx_start pulse.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_WAIT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  tx_en,
  input  logic                  clr_ovf,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(BUSY_WAIT + 1);

  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH_LOG2'(0) | (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [TW-1:0]         TMR_ONE  = 1;
  localparam logic [TW-1:0]         TMR_LAST = TW'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  full_reg, empty_reg, overflow_reg;
  logic                  tx_start_reg;
  logic [7:0]            tx_data_reg;
  state_t                state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  push, pop;

  // Pop decision uses registered status only, so a byte written into an
  // empty FIFO can never be popped on the same edge it is stored.
  assign push = wr_en && !full_reg;
  assign pop  = (state_reg == IDLE) && tx_en && !empty_reg && !tx_busy;

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Storage array; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, registered status flags and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_FULL);
      empty_reg <= (count_next == '0);
      // A dropped write wins over a simultaneous clear.
      if (wr_en && full_reg) overflow_reg <= 1'b1;
      else if (clr_ovf)      overflow_reg <= 1'b0;
    end
  end

  // Drain FSM next-state: launch, wait for busy (or give up), wait for idle.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        if (pop) state_next = LAUNCH;
      end
      LAUNCH: begin
        state_next = WAIT_BUSY;
        timer_next = '0;
      end
      WAIT_BUSY: begin
        // A transmitter that never reports busy must not stall the FIFO.
        if (tx_busy || timer_reg == TMR_LAST) state_next = WAIT_DONE;
        else                                  timer_next = timer_reg + TMR_ONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, wait timer and the launch handshake registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      tx_start_reg <= pop;
      if (pop) tx_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

endmodule
